// File: rtl/ad_clk_pkg.sv
// Shared types, limits and sizing helpers for the AD model clock/reset blocks.
package ad_clk_pkg;

   typedef enum logic [2:0] {
      PLL_RST,
      WAIT_LOCK,
      FILTER,
      RELEASE,
      RUN
   } ad_rst_state_t;

   localparam logic [7:0] CNT_SAT = 8'hFF;

   // Bits needed to hold values 0..max_val.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic int max_of4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/ad_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; clears to 0 on reset.
module ad_sync_2ff #(
   parameter int DATA_W = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   logic [DATA_W-1:0] sync_p0;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_p0 <= '0;
         q       <= '0;
      end else begin
         sync_p0 <= d;
         q       <= sync_p0;
      end
   end

endmodule

// File: rtl/ad_reset_seq.sv
// PLL/DCM bring-up sequencer: pulses the PLL reset, waits for and debounces lock,
// then releases the downstream reset domains in order; lock loss restarts the sequence.
module ad_reset_seq
   import ad_clk_pkg::*;
#(
   parameter int NUM_STAGES          = 3,
   parameter int PLL_RST_CYCLES      = 4,
   parameter int LOCK_FILTER_CYCLES  = 16,
   parameter int STAGE_GAP_CYCLES    = 8,
   parameter int LOCK_TIMEOUT_CYCLES = 4096
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  lock_in,
   output logic                  pll_reset,
   output logic [NUM_STAGES-1:0] stage_reset,
   output logic                  ready,
   output logic                  lock_lost,
   output logic [7:0]            retry_cnt,
   output logic [7:0]            lost_cnt
);

   localparam int CNT_W = cnt_width(max_of4(PLL_RST_CYCLES, LOCK_FILTER_CYCLES,
                                            STAGE_GAP_CYCLES, LOCK_TIMEOUT_CYCLES));
   localparam int IDX_W = cnt_width(NUM_STAGES);

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] PLL_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILTER_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_DONE  = IDX_W'(NUM_STAGES);

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == CNT_SAT) ? v : v + 8'd1;
   endfunction

   logic                  lock_s;
   ad_rst_state_t         state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  pll_reset_d;
   logic [NUM_STAGES-1:0] stage_d;
   logic                  ready_d;
   logic                  lock_lost_d;
   logic [7:0]            retry_d, lost_d;

   ad_sync_2ff #(
      .DATA_W (1)
   ) u_lock_sync (
      .clk   (clk),
      .reset (reset),
      .d     (lock_in),
      .q     (lock_s)
   );

   // cnt_q is the per-state timer: PLL hold, lock timeout, filter run length or stage gap.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      pll_reset_d = pll_reset;
      stage_d     = stage_reset;
      ready_d     = ready;
      lock_lost_d = 1'b0;
      retry_d     = retry_cnt;
      lost_d      = lost_cnt;

      case (state_q)
         PLL_RST: begin
            if (cnt_q == PLL_LAST) begin
               state_d     = WAIT_LOCK;
               cnt_d       = '0;
               pll_reset_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         WAIT_LOCK: begin
            // Lock takes priority over a timeout landing on the same cycle.
            if (lock_s) begin
               if (LOCK_FILTER_CYCLES == 1) begin
                  state_d    = RELEASE;
                  cnt_d      = '0;
                  idx_d      = IDX_ONE;
                  stage_d[0] = 1'b0;
               end else begin
                  state_d = FILTER;
                  cnt_d   = CNT_ONE;
               end
            end else if (cnt_q == TO_LAST) begin
               state_d     = PLL_RST;
               cnt_d       = '0;
               pll_reset_d = 1'b1;
               retry_d     = sat_inc(retry_cnt);
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         FILTER: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == FILT_LAST) begin
               state_d    = RELEASE;
               cnt_d      = '0;
               idx_d      = IDX_ONE;
               stage_d[0] = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         RELEASE, RUN: begin
            if (!lock_s) begin
               state_d     = WAIT_LOCK;
               cnt_d       = '0;
               idx_d       = '0;
               stage_d     = '1;
               ready_d     = 1'b0;
               lock_lost_d = 1'b1;
               lost_d      = sat_inc(lost_cnt);
            end else if (state_q == RELEASE) begin
               if (cnt_q == GAP_LAST) begin
                  cnt_d = '0;
                  if (idx_q == IDX_DONE) begin
                     state_d = RUN;
                     ready_d = 1'b1;
                  end else begin
                     for (int k = 0; k < NUM_STAGES; k++) begin
                        if (idx_q == IDX_W'(k)) stage_d[k] = 1'b0;
                     end
                     idx_d = idx_q + IDX_ONE;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end

         default: begin
            state_d = PLL_RST;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= PLL_RST;
         cnt_q       <= '0;
         idx_q       <= '0;
         pll_reset   <= 1'b1;
         stage_reset <= '1;
         ready       <= 1'b0;
         lock_lost   <= 1'b0;
         retry_cnt   <= '0;
         lost_cnt    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         pll_reset   <= pll_reset_d;
         stage_reset <= stage_d;
         ready       <= ready_d;
         lock_lost   <= lock_lost_d;
         retry_cnt   <= retry_d;
         lost_cnt    <= lost_d;
      end
   end

endmodule

// File: tb/tb_ad_reset_seq.sv
// Bench for ad_reset_seq: a timestamp-based reference model runs alongside the DUT,
// and each scenario task compares against it and against hand-derived cycle numbers.
module tb_ad_reset_seq;

   localparam int NS  = 3;
   localparam int PR  = 4;
   localparam int LF  = 16;
   localparam int GAP = 8;
   localparam int TO  = 4096;

   localparam logic [21:0] RST_VEC = {1'b1, 3'b111, 1'b0, 1'b0, 8'd0, 8'd0};

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          lock_in = 1'b0;
   logic          pll_reset;
   logic [NS-1:0] stage_reset;
   logic          ready;
   logic          lock_lost;
   logic [7:0]    retry_cnt;
   logic [7:0]    lost_cnt;

   logic          reset_sat = 1'b1;
   logic          sat_pll;
   logic [0:0]    sat_stage;
   logic          sat_ready;
   logic          sat_lost_pulse;
   logic [7:0]    sat_retry;
   logic [7:0]    sat_lost;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ad_reset_seq #(
      .NUM_STAGES          (NS),
      .PLL_RST_CYCLES      (PR),
      .LOCK_FILTER_CYCLES  (LF),
      .STAGE_GAP_CYCLES    (GAP),
      .LOCK_TIMEOUT_CYCLES (TO)
   ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .lock_in     (lock_in),
      .pll_reset   (pll_reset),
      .stage_reset (stage_reset),
      .ready       (ready),
      .lock_lost   (lock_lost),
      .retry_cnt   (retry_cnt),
      .lost_cnt    (lost_cnt)
   );

   // Short timeout instance so retry saturation is reachable quickly.
   ad_reset_seq #(
      .NUM_STAGES          (1),
      .PLL_RST_CYCLES      (1),
      .LOCK_FILTER_CYCLES  (LF),
      .STAGE_GAP_CYCLES    (GAP),
      .LOCK_TIMEOUT_CYCLES (2)
   ) u_sat (
      .clk         (clk),
      .reset       (reset_sat),
      .lock_in     (1'b0),
      .pll_reset   (sat_pll),
      .stage_reset (sat_stage),
      .ready       (sat_ready),
      .lock_lost   (sat_lost_pulse),
      .retry_cnt   (sat_retry),
      .lost_cnt    (sat_lost)
   );

   logic [21:0] dut_vec;
   assign dut_vec = {pll_reset, stage_reset, ready, lock_lost, retry_cnt, lost_cnt};

   // Reference model: phases with start timestamps; releases follow from t0 arithmetic.
   localparam int M_PLL  = 0;
   localparam int M_WAIT = 1;
   localparam int M_LOCK = 2;

   int          cyc = 0;
   int          m_phase = M_PLL;
   int          m_ps = 0;
   int          m_ws = 0;
   int          m_t0 = 0;
   int          m_pulse_at = -1;
   int          m_retry = 0;
   int          m_lost = 0;
   bit          m_s1 = 1'b0;
   bit          m_ls = 1'b0;
   logic [NS-1:0] exp_stage;
   logic [21:0] exp_vec = RST_VEC;

   initial begin
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
         if (reset) begin
            m_phase    = M_PLL;
            m_ps       = cyc;
            m_retry    = 0;
            m_lost     = 0;
            m_pulse_at = -1;
            m_s1       = 1'b0;
            m_ls       = 1'b0;
         end else begin
            case (m_phase)
               M_PLL: begin
                  if (cyc - m_ps == PR) begin
                     m_phase = M_WAIT;
                     m_ws    = cyc;
                  end
               end
               M_WAIT: begin
                  if (m_ls) begin
                     m_phase = M_LOCK;
                     m_t0    = cyc - 1;
                  end else if (cyc - m_ws == TO) begin
                     m_phase = M_PLL;
                     m_ps    = cyc;
                     if (m_retry < 255) m_retry = m_retry + 1;
                  end
               end
               default: begin
                  if (!m_ls) begin
                     if (cyc - 1 >= m_t0 + LF) begin
                        m_pulse_at = cyc;
                        if (m_lost < 255) m_lost = m_lost + 1;
                     end
                     m_phase = M_WAIT;
                     m_ws    = cyc;
                  end
               end
            endcase
            m_ls = m_s1;
            m_s1 = lock_in;
         end
         exp_stage = '1;
         for (int k = 0; k < NS; k++) begin
            if (m_phase == M_LOCK && cyc >= m_t0 + LF + k * GAP) exp_stage[k] = 1'b0;
         end
         exp_vec = {m_phase == M_PLL, exp_stage,
                    m_phase == M_LOCK && cyc >= m_t0 + LF + NS * GAP,
                    m_pulse_at == cyc, 8'(m_retry), 8'(m_lost)};
      end
   end

   task automatic do_reset(input int n);
      @(negedge clk);
      reset = 1'b1;
      repeat (n) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      lock_in = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (dut_vec !== RST_VEC) begin
         errors++;
         $display("FAIL reset_values got %h want %h", dut_vec, RST_VEC);
      end
      checks++;
      if (dut_vec !== exp_vec) begin
         errors++;
         $display("FAIL reset_model got %h want %h", dut_vec, exp_vec);
      end
      lock_in = 1'b0;
   endtask

   task automatic test_clean_bringup();
      int pll_hi = 0;
      int f0 = -1, f1 = -1, f2 = -1, fr = -1;
      lock_in = 1'b0;
      do_reset(3);
      for (int rel = 0; rel <= 60; rel++) begin
         if (rel > 0) @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL bringup cyc %0d got %h want %h", rel, dut_vec, exp_vec);
         end
         if (pll_reset) pll_hi++;
         if (f0 < 0 && !stage_reset[0]) f0 = rel;
         if (f1 < 0 && !stage_reset[1]) f1 = rel;
         if (f2 < 0 && !stage_reset[2]) f2 = rel;
         if (fr < 0 && ready) fr = rel;
         if (rel == 10) lock_in = 1'b1;
      end
      checks++;
      if (pll_hi !== 4) begin errors++; $display("FAIL bringup_pll_cycles got %0d want 4", pll_hi); end
      checks++;
      if (f0 !== 28) begin errors++; $display("FAIL bringup_stage0 got %0d want 28", f0); end
      checks++;
      if (f1 !== 36) begin errors++; $display("FAIL bringup_stage1 got %0d want 36", f1); end
      checks++;
      if (f2 !== 44) begin errors++; $display("FAIL bringup_stage2 got %0d want 44", f2); end
      checks++;
      if (fr !== 52) begin errors++; $display("FAIL bringup_ready got %0d want 52", fr); end
      checks++;
      if ({retry_cnt, lost_cnt} !== 16'd0) begin
         errors++;
         $display("FAIL bringup_counters got %h want 0000", {retry_cnt, lost_cnt});
      end
   endtask

   task automatic test_filter_glitch();
      int f0 = -1, ll_hi = 0;
      lock_in = 1'b0;
      do_reset(2);
      for (int rel = 0; rel <= 80; rel++) begin
         if (rel > 0) @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL glitch cyc %0d got %h want %h", rel, dut_vec, exp_vec);
         end
         if (f0 < 0 && !stage_reset[0]) f0 = rel;
         if (lock_lost) ll_hi++;
         lock_in = (rel >= 10) && (rel != 15);
      end
      checks++;
      if (f0 !== 34) begin errors++; $display("FAIL glitch_release got %0d want 34", f0); end
      checks++;
      if (ll_hi !== 0 || lost_cnt !== 8'd0) begin
         errors++;
         $display("FAIL glitch_no_loss got pulses %0d lost %0d want 0 0", ll_hi, lost_cnt);
      end
   endtask

   task automatic test_timeout();
      lock_in = 1'b0;
      do_reset(2);
      for (int rel = 0; rel <= 8210; rel++) begin
         if (rel > 0) @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL timeout cyc %0d got %h want %h", rel, dut_vec, exp_vec);
         end
         if (rel == 4099) begin
            checks++;
            if (retry_cnt !== 8'd0) begin errors++; $display("FAIL timeout_before got %0d want 0", retry_cnt); end
         end
         if (rel == 4100 || rel == 4103) begin
            checks++;
            if ({pll_reset, retry_cnt} !== {1'b1, 8'd1}) begin
               errors++;
               $display("FAIL timeout_repulse cyc %0d got pll %b retry %0d want 1 1", rel, pll_reset, retry_cnt);
            end
         end
         if (rel == 4104) begin
            checks++;
            if (pll_reset !== 1'b0) begin errors++; $display("FAIL timeout_pll_end got %b want 0", pll_reset); end
         end
         if (rel == 8200) begin
            checks++;
            if (retry_cnt !== 8'd2) begin errors++; $display("FAIL timeout_second got %0d want 2", retry_cnt); end
         end
      end
   endtask

   task automatic test_loss_run();
      int ll_hi = 0, ll_at = -1, pll_late = 0, f0 = -1, fr = -1;
      lock_in = 1'b0;
      do_reset(2);
      for (int rel = 0; rel <= 120; rel++) begin
         if (rel > 0) @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL loss_run cyc %0d got %h want %h", rel, dut_vec, exp_vec);
         end
         if (lock_lost) begin ll_hi++; if (ll_at < 0) ll_at = rel; end
         if (rel >= 4 && pll_reset) pll_late++;
         if (rel == 63) begin
            checks++;
            if ({stage_reset, ready} !== 4'b1110) begin
               errors++;
               $display("FAIL loss_run_reassert got %b want 1110", {stage_reset, ready});
            end
         end
         if (rel > 63 && f0 < 0 && !stage_reset[0]) f0 = rel;
         if (rel > 63 && fr < 0 && ready) fr = rel;
         lock_in = (rel >= 10) && !(rel >= 60 && rel < 70);
      end
      checks++;
      if (ll_hi !== 1 || ll_at !== 63) begin
         errors++;
         $display("FAIL loss_run_pulse got %0d at %0d want 1 at 63", ll_hi, ll_at);
      end
      checks++;
      if (lost_cnt !== 8'd1) begin errors++; $display("FAIL loss_run_count got %0d want 1", lost_cnt); end
      checks++;
      if (pll_late !== 0) begin errors++; $display("FAIL loss_run_pll got %0d want 0", pll_late); end
      checks++;
      if (f0 !== 88 || fr !== 112) begin
         errors++;
         $display("FAIL loss_run_relock got %0d/%0d want 88/112", f0, fr);
      end
   endtask

   task automatic test_loss_release();
      int f0 = -1, f1 = -1, f2 = -1, fr = -1;
      lock_in = 1'b0;
      do_reset(2);
      for (int rel = 0; rel <= 85; rel++) begin
         if (rel > 0) @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL loss_rel cyc %0d got %h want %h", rel, dut_vec, exp_vec);
         end
         if (rel == 30) begin
            checks++;
            if (stage_reset !== 3'b110) begin errors++; $display("FAIL loss_rel_before got %b want 110", stage_reset); end
         end
         if (rel == 31) begin
            checks++;
            if ({stage_reset, lock_lost} !== 4'b1111) begin
               errors++;
               $display("FAIL loss_rel_reassert got %b want 1111", {stage_reset, lock_lost});
            end
         end
         if (rel > 31) begin
            if (f0 < 0 && !stage_reset[0]) f0 = rel;
            if (f1 < 0 && !stage_reset[1]) f1 = rel;
            if (f2 < 0 && !stage_reset[2]) f2 = rel;
            if (fr < 0 && ready) fr = rel;
         end
         lock_in = (rel >= 10) && !(rel >= 28 && rel < 35);
      end
      checks++;
      if ({f0, f1, f2, fr} !== {32'd53, 32'd61, 32'd69, 32'd77}) begin
         errors++;
         $display("FAIL loss_rel_order got %0d/%0d/%0d/%0d want 53/61/69/77", f0, f1, f2, fr);
      end
   endtask

   task automatic test_mid_reset();
      lock_in = 1'b0;
      do_reset(2);
      for (int rel = 0; rel <= 239; rel++) begin
         if (rel > 0) @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL midrst cyc %0d got %h want %h", rel, dut_vec, exp_vec);
         end
         lock_in = (rel >= 10) && !(rel >= 60 && (rel % 60) < 3);
      end
      checks++;
      if ({ready, lost_cnt} !== {1'b1, 8'd3}) begin
         errors++;
         $display("FAIL midrst_setup got ready %b lost %0d want 1 3", ready, lost_cnt);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (dut_vec !== RST_VEC) begin
         errors++;
         $display("FAIL midrst_values got %h want %h", dut_vec, RST_VEC);
      end
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
         errors++;
         $display("FAIL midrst_after got %h want %h", dut_vec, exp_vec);
      end
   endtask

   task automatic test_random();
      lock_in = 1'b0;
      do_reset(2);
      for (int rel = 0; rel < 3000; rel++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL random cyc %0d got %h want %h", rel, dut_vec, exp_vec);
         end
         if (reset) reset = 1'b0;
         else if ($urandom_range(0, 999) == 0) reset = 1'b1;
         if (lock_in) begin
            if ($urandom_range(0, 59) == 0) lock_in = 1'b0;
         end else if ($urandom_range(0, 5) == 0) begin
            lock_in = 1'b1;
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_saturation();
      @(negedge clk);
      reset_sat = 1'b1;
      @(negedge clk);
      reset_sat = 1'b0;
      for (int rel = 0; rel <= 800; rel++) begin
         if (rel > 0) @(negedge clk);
         if (rel == 3) begin
            checks++;
            if ({sat_pll, sat_retry} !== {1'b1, 8'd1}) begin
               errors++;
               $display("FAIL sat_first got pll %b retry %0d want 1 1", sat_pll, sat_retry);
            end
         end
         if (rel == 4) begin
            checks++;
            if (sat_pll !== 1'b0) begin errors++; $display("FAIL sat_pll_end got %b want 0", sat_pll); end
         end
         if (rel == 764) begin
            checks++;
            if (sat_retry !== 8'd254) begin errors++; $display("FAIL sat_254 got %0d want 254", sat_retry); end
         end
         if (rel == 765 || rel == 800) begin
            checks++;
            if (sat_retry !== 8'd255) begin
               errors++;
               $display("FAIL sat_hold cyc %0d got %0d want 255", rel, sat_retry);
            end
         end
      end
      checks++;
      if ({sat_stage, sat_ready, sat_lost_pulse, sat_lost} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
         errors++;
         $display("FAIL sat_idle got %b want 100 00000000",
                  {sat_stage, sat_ready, sat_lost_pulse, sat_lost});
      end
   endtask

   initial begin
      test_reset();
      test_clean_bringup();
      test_filter_glitch();
      test_loss_run();
      test_loss_release();
      test_mid_reset();
      test_timeout();
      test_random();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
